forward_scoreboard: RTL and testbench
=====================================

Name: forward_scoreboard

Overview:
- Parametrised successor to the fixed two-source forwarding select (none / EX-MEM / MEM-WB).
- Tracks in-flight register writers across DEPTH post-decode pipeline stages in a shift-register scoreboard.
- Drives a per-operand forwarding select and a load-use stall, and counts stall cycles for performance monitoring.
- Sits beside decode; its selects drive the operand muxes in EX.

Parameters:
- REG_W, 3: register address width.
- NUM_SRC, 2: number of source operands checked per issued instruction.
- DEPTH, 2: tracked stages after decode. Stage 1 is the youngest (EX); stage DEPTH is the oldest (WB).
- LOAD_READY, 2: first stage at which memRead data is forwardable. Must be in the range 1..DEPTH.
- ZERO_REG, 0: if 1, register 0 never matches.
- FLUSH_STAGES, 1: number of youngest tracked stages invalidated on flush.
- SEL_W, $clog2(DEPTH+1): width of each select field.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- issue_valid, in, 1: decode holds a real instruction.
- issue_rd, in, REG_W: destination of the decode instruction.
- issue_regWrite, in, 1: decode instruction writes rd.
- issue_memRead, in, 1: decode instruction is a load.
- src_addr, in, NUM_SRC*REG_W: source addresses; operand i is bits [i*REG_W +: REG_W].
- src_used, in, NUM_SRC: operand i is actually read.
- freeze, in, 1: external pipeline hold.
- flush, in, 1: branch taken; squash younger instructions.
- fwd_sel, out, NUM_SRC*SEL_W: per-operand select. 0 = register file; k = forward from stage k.
- stall, out, 1: load-use hazard; hold decode and fetch.
- stall_count, out, 16: saturating count of stall cycles.

Behaviour:
- Scoreboard entry format, per stage: {valid, rd, regWrite, memRead}.
- Reset (synchronous):
  - All entries cleared to invalid.
  - stall_count = 0.
  - While reset is asserted, fwd_sel = 0 and stall = 0.
  - Reset in mid-stream discards all in-flight entries; there are no partial effects.
- Match rule: operand i matches stage k when all of the following hold:
  - src_used[i] = 1.
  - The stage k entry has valid = 1 and regWrite = 1.
  - rd == src_addr[i].
  - Not (ZERO_REG = 1 and src_addr[i] == 0).
- fwd_sel[i] is combinational: the smallest matching k (youngest producer wins), or 0 if no stage matches.
- stall is combinational. It is 1 when, for any operand, the youngest matching stage k holds memRead = 1 and k < LOAD_READY.
  - An older load is ignored if a younger non-load producer of the same register matches.
- Operands with src_used = 0 never contribute to stall.
- Sequential update at each clk edge, priority highest first:
  1. reset: clear, as above.
  2. freeze: hold all entries; stall_count unchanged.
  3. flush: invalidate stages 1..FLUSH_STAGES, shift the remaining stages one position older, and insert a bubble at stage 1. Flush wins over stall.
  4. stall: shift one position older, insert a bubble at stage 1 (decode instruction not accepted), and increment stall_count.
  5. Normal: shift one position older and insert {issue_valid, issue_rd, issue_regWrite, issue_memRead} at stage 1.
- Shifting drops the stage DEPTH entry (write-back retires it).
- The register file is assumed write-before-read; there is no DEPTH+1 match.
- stall_count saturates at 16'hFFFF and does not wrap. It increments only in the stall case of the update priority, never under freeze or flush.
- Latency:
  - A producer issued at edge N is visible as stage 1 from cycle N+1.
  - Producers advance one stage per non-frozen cycle.
- With DEPTH = 2, select values 1 and 2 correspond to the legacy FORWARD_MEM and FORWARD_WB selects respectively.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: issue rd=3, regWrite; next cycle src_addr[0]=3, src_used=01.
  - Expected: fwd_sel[0]=1, stall=0. One cycle later with no other writer: fwd_sel[0]=2. One further cycle later: 0.
- Youngest wins:
  - Stimulus: writers to r5 issued on consecutive cycles; then read r5.
  - Expected: fwd_sel=1, not 2.
- Load-use:
  - Stimulus: issue load rd=4 (memRead=1, LOAD_READY=2); next cycle read r4.
  - Expected: stall=1 for exactly one cycle, a bubble is inserted, the load advances to stage 2, then fwd_sel=2, stall=0, and stall_count=1.
- Freeze and flush:
  - Freeze: asserting freeze during the load-use stall holds stall=1, with stall_count unchanged for 3 frozen cycles.
  - Flush: asserting flush with the stage 1 writer to r6 makes a subsequent read of r6 give fwd_sel=0.
- Zero register and unused operands:
  - Stimulus: ZERO_REG=1; writer to r0, then read r0; separately, a matching source with src_used=0.
  - Expected: fwd_sel=0 and stall=0 in both cases.
- Saturation and reset:
  - Stimulus: preload stall_count to FFFE via a forced sequence of stalls; apply 3 more stalls.
  - Expected: stall_count stays at FFFF.
  - Stimulus: then reset for one cycle.
  - Expected: count 0, all selects 0, stall 0.

Source files
------------

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: shift-register scoreboard of in-flight register writers.
// Produces per-operand forwarding selects (youngest producer wins), a load-use
// stall, and a saturating count of stall cycles.
module forward_scoreboard #(
  parameter int unsigned REG_W        = 3,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned LOAD_READY   = 2,
  parameter int unsigned ZERO_REG     = 0,
  parameter int unsigned FLUSH_STAGES = 1,
  parameter int unsigned SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic                     issue_regWrite,
  input  logic                     issue_memRead,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     freeze,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [15:0]              stall_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 is the youngest (EX), stage DEPTH the oldest (WB).
  logic             stValid [1:DEPTH];
  logic [REG_W-1:0] stRd    [1:DEPTH];
  logic             stWrite [1:DEPTH];
  logic             stLoad  [1:DEPTH];

  logic [NUM_SRC*SEL_W-1:0] selComb;
  logic [NUM_SRC-1:0]       found;
  logic                     hazard;

  // Youngest matching producer per operand; stall if that producer is a load
  // whose data is not yet forwardable.
  always_comb begin
    selComb = '0;
    found   = '0;
    hazard  = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        if (!found[i] && src_used[i] && stValid[k] && stWrite[k] &&
            (stRd[k] == src_addr[i*REG_W +: REG_W]) &&
            !((ZERO_REG != 0) && (src_addr[i*REG_W +: REG_W] == '0))) begin
          found[i]                   = 1'b1;
          selComb[i*SEL_W +: SEL_W]  = SEL_W'(k);
          if (stLoad[k] && (k < int'(LOAD_READY))) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held.
  assign fwd_sel = reset ? '0 : selComb;
  assign stall   = hazard & ~reset;

  // Scoreboard advance: reset > freeze > flush > stall > normal issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        stValid[k] <= 1'b0;
        stRd[k]    <= '0;
        stWrite[k] <= 1'b0;
        stLoad[k]  <= 1'b0;
      end
      stall_count <= '0;
    end else if (!freeze) begin
      for (int k = 2; k <= int'(DEPTH); k++) begin
        stValid[k] <= stValid[k-1] && !(flush && ((k - 1) <= int'(FLUSH_STAGES)));
        stRd[k]    <= stRd[k-1];
        stWrite[k] <= stWrite[k-1];
        stLoad[k]  <= stLoad[k-1];
      end
      // Flush or stall inserts a bubble; otherwise decode enters stage 1.
      stValid[1] <= issue_valid && !flush && !hazard;
      stRd[1]    <= issue_rd;
      stWrite[1] <= issue_regWrite;
      stLoad[1]  <= issue_memRead;
      if (!flush && hazard && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed scenarios plus random
// stimulus compared against a behavioural in-flight-instruction model.
module tb_forward_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic        issue_regWrite;
  logic        issue_memRead;
  logic [5:0]  src_addr;
  logic [1:0]  src_used;
  logic        freeze;
  logic        flush;

  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_count;
  logic [3:0]  zFwdSel;
  logic        zStall;
  logic [15:0] zCount;
  logic [9:0]  sFwdSel;
  logic        sStall;
  logic [15:0] sCount;

  int nChecks = 0;
  int nErrors = 0;

  // Default configuration.
  forward_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regWrite(issue_regWrite), .issue_memRead(issue_memRead),
    .src_addr(src_addr), .src_used(src_used), .freeze(freeze), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  // Register 0 never matches.
  forward_scoreboard #(.ZERO_REG(1)) zdut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regWrite(issue_regWrite), .issue_memRead(issue_memRead),
    .src_addr(src_addr), .src_used(src_used), .freeze(freeze), .flush(flush),
    .fwd_sel(zFwdSel), .stall(zStall), .stall_count(zCount)
  );

  // Deep, late-forwarding pipe: a single load stalls 15 of every 16 cycles.
  forward_scoreboard #(.DEPTH(16), .LOAD_READY(16)) sdut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regWrite(issue_regWrite), .issue_memRead(issue_memRead),
    .src_addr(src_addr), .src_used(src_used), .freeze(freeze), .flush(flush),
    .fwd_sel(sFwdSel), .stall(sStall), .stall_count(sCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the instructions in flight, indexed by age in cycles.
  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       w;
    logic       m;
  } ent_t;

  ent_t pipe [1:2];
  int   mCount;

  function automatic int expSelOp(int i);
    for (int k = 1; k <= 2; k++) begin
      if (src_used[i] && pipe[k].v && pipe[k].w && pipe[k].rd == src_addr[i*3 +: 3]) return k;
    end
    return 0;
  endfunction

  function automatic logic expStall();
    if (reset) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      int k;
      k = expSelOp(i);
      if (k == 1 && pipe[1].m) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] expSel();
    logic [3:0] r;
    r = {2'(expSelOp(1)), 2'(expSelOp(0))};
    if (reset) r = '0;
    return r;
  endfunction

  task automatic mdlUpdate(input logic st);
    if (reset) begin
      pipe[1] = '0;
      pipe[2] = '0;
      mCount  = 0;
    end else if (freeze) begin
      mCount = mCount;
    end else if (flush) begin
      pipe[2] = '0;
      pipe[1] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = st ? ent_t'('0) : ent_t'({issue_valid, issue_rd, issue_regWrite, issue_memRead});
      if (st && mCount < 65535) mCount = mCount + 1;
    end
  endtask

  // Advance one clock, keeping the model in lockstep; returns at negedge.
  task automatic tick();
    logic st;
    st = expStall();
    @(posedge clk);
    mdlUpdate(st);
    @(negedge clk);
  endtask

  task automatic idle();
    reset          = 1'b0;
    issue_valid    = 1'b0;
    issue_rd       = 3'd0;
    issue_regWrite = 1'b0;
    issue_memRead  = 1'b0;
    src_addr       = 6'd0;
    src_used       = 2'b00;
    freeze         = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic ld);
    issue_valid    = 1'b1;
    issue_rd       = rd;
    issue_regWrite = 1'b1;
    issue_memRead  = ld;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    nChecks++;
    if (stall_count !== 16'd0 || fwd_sel !== 4'd0 || stall !== 1'b0) begin
      nErrors++;
      $display("FAIL reset_state: count=%0h sel=%0h stall=%0b expected 0/0/0", stall_count, fwd_sel, stall);
    end
    issue(3'd4, 1'b1);
    tick();
    idle();
    src_addr = 6'o04;
    src_used = 2'b01;
    #1;
    nChecks++;
    if (stall !== 1'b1) begin
      nErrors++;
      $display("FAIL reset_pre_stall: stall=%0b expected 1", stall);
    end
    reset = 1'b1;
    #1;
    nChecks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
      nErrors++;
      $display("FAIL reset_gating: stall=%0b sel=%0h expected 0/0", stall, fwd_sel);
    end
    tick();
    reset = 1'b0;
    #1;
    nChecks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0 || stall_count !== 16'd0) begin
      nErrors++;
      $display("FAIL reset_discard: stall=%0b sel=%0h count=%0h expected 0/0/0", stall, fwd_sel, stall_count);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    issue(3'd3, 1'b0);
    tick();
    idle();
    src_addr = 6'o03;
    src_used = 2'b01;
    #1;
    nChecks++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
      nErrors++;
      $display("FAIL b2b_stage1: sel=%0d stall=%0b expected 1/0", fwd_sel[1:0], stall);
    end
    tick();
    #1;
    nChecks++;
    if (fwd_sel[1:0] !== 2'd2) begin
      nErrors++;
      $display("FAIL b2b_stage2: sel=%0d expected 2", fwd_sel[1:0]);
    end
    tick();
    #1;
    nChecks++;
    if (fwd_sel[1:0] !== 2'd0) begin
      nErrors++;
      $display("FAIL b2b_retired: sel=%0d expected 0", fwd_sel[1:0]);
    end
  endtask

  task automatic test_youngest_wins();
    doReset();
    issue(3'd5, 1'b0);
    tick();
    issue(3'd5, 1'b0);
    tick();
    idle();
    src_addr = 6'o55;
    src_used = 2'b11;
    #1;
    nChecks++;
    if (fwd_sel !== 4'b0101 || stall !== 1'b0) begin
      nErrors++;
      $display("FAIL youngest_wins: sel=%0h stall=%0b expected 5/0", fwd_sel, stall);
    end
  endtask

  task automatic test_load_use();
    doReset();
    issue(3'd4, 1'b1);
    tick();
    issue(3'd7, 1'b0);
    src_addr = 6'o40;
    src_used = 2'b10;
    #1;
    nChecks++;
    if (stall !== 1'b1 || fwd_sel[3:2] !== 2'd1) begin
      nErrors++;
      $display("FAIL load_use_stall: stall=%0b sel=%0d expected 1/1", stall, fwd_sel[3:2]);
    end
    tick();
    #1;
    nChecks++;
    if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2 || stall_count !== 16'd1) begin
      nErrors++;
      $display("FAIL load_use_release: stall=%0b sel=%0d count=%0d expected 0/2/1", stall, fwd_sel[3:2], stall_count);
    end
    tick();
    idle();
    src_addr = 6'o70;
    src_used = 2'b10;
    #1;
    nChecks++;
    if (fwd_sel[3:2] !== 2'd1 || stall_count !== 16'd1) begin
      nErrors++;
      $display("FAIL load_use_accept: sel=%0d count=%0d expected 1/1", fwd_sel[3:2], stall_count);
    end
  endtask

  task automatic test_freeze_flush();
    doReset();
    issue(3'd4, 1'b1);
    tick();
    issue(3'd7, 1'b0);
    src_addr = 6'o04;
    src_used = 2'b01;
    freeze   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      nChecks++;
      if (stall !== 1'b1 || stall_count !== 16'd0) begin
        nErrors++;
        $display("FAIL freeze_hold[%0d]: stall=%0b count=%0d expected 1/0", c, stall, stall_count);
      end
      tick();
    end
    freeze = 1'b0;
    #1;
    nChecks++;
    if (stall !== 1'b1) begin
      nErrors++;
      $display("FAIL freeze_release: stall=%0b expected 1", stall);
    end
    tick();
    #1;
    nChecks++;
    if (stall !== 1'b0 || stall_count !== 16'd1 || fwd_sel[1:0] !== 2'd2) begin
      nErrors++;
      $display("FAIL freeze_after: stall=%0b count=%0d sel=%0d expected 0/1/2", stall, stall_count, fwd_sel[1:0]);
    end
    idle();
    issue(3'd6, 1'b0);
    tick();
    issue(3'd2, 1'b0);
    src_addr = 6'o06;
    src_used = 2'b01;
    flush    = 1'b1;
    #1;
    nChecks++;
    if (fwd_sel[1:0] !== 2'd1) begin
      nErrors++;
      $display("FAIL flush_pre: sel=%0d expected 1", fwd_sel[1:0]);
    end
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    #1;
    nChecks++;
    if (fwd_sel[1:0] !== 2'd0) begin
      nErrors++;
      $display("FAIL flush_squash: sel=%0d expected 0", fwd_sel[1:0]);
    end
    issue(3'd4, 1'b1);
    tick();
    issue(3'd1, 1'b0);
    src_addr = 6'o04;
    flush    = 1'b1;
    tick();
    idle();
    #1;
    nChecks++;
    if (stall_count !== 16'd1 || fwd_sel !== 4'd0) begin
      nErrors++;
      $display("FAIL flush_over_stall: count=%0d sel=%0h expected 1/0", stall_count, fwd_sel);
    end
  endtask

  task automatic test_zero_unused();
    doReset();
    issue(3'd0, 1'b0);
    tick();
    idle();
    src_addr = 6'o00;
    src_used = 2'b01;
    #1;
    nChecks++;
    if (zFwdSel !== 4'd0 || zStall !== 1'b0 || fwd_sel[1:0] !== 2'd1) begin
      nErrors++;
      $display("FAIL zero_reg_alu: zsel=%0h zstall=%0b sel=%0d expected 0/0/1", zFwdSel, zStall, fwd_sel[1:0]);
    end
    issue(3'd0, 1'b1);
    tick();
    idle();
    src_used = 2'b11;
    #1;
    nChecks++;
    if (zFwdSel !== 4'd0 || zStall !== 1'b0) begin
      nErrors++;
      $display("FAIL zero_reg_load: zsel=%0h zstall=%0b expected 0/0", zFwdSel, zStall);
    end
    doReset();
    issue(3'd2, 1'b1);
    tick();
    idle();
    src_addr = 6'o22;
    src_used = 2'b00;
    #1;
    nChecks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      nErrors++;
      $display("FAIL unused_operand: sel=%0h stall=%0b expected 0/0", fwd_sel, stall);
    end
  endtask

  task automatic test_random();
    logic [3:0] es;
    logic       est;
    doReset();
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(99) < 2);
      freeze         = ($urandom_range(99) < 10);
      flush          = ($urandom_range(99) < 8);
      issue_valid    = ($urandom_range(99) < 80);
      issue_rd       = 3'($urandom_range(3));
      issue_regWrite = ($urandom_range(99) < 80);
      issue_memRead  = ($urandom_range(99) < 35);
      src_addr       = {3'($urandom_range(3)), 3'($urandom_range(3))};
      src_used       = 2'($urandom_range(3));
      #1;
      es  = expSel();
      est = expStall();
      nChecks++;
      if (fwd_sel !== es) begin
        nErrors++;
        $display("FAIL rand_sel[%0d]: got %0h expected %0h", c, fwd_sel, es);
      end
      nChecks++;
      if (stall !== est) begin
        nErrors++;
        $display("FAIL rand_stall[%0d]: got %0b expected %0b", c, stall, est);
      end
      tick();
      #1;
      nChecks++;
      if (stall_count !== 16'(mCount)) begin
        nErrors++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", c, stall_count, mCount);
      end
    end
  endtask

  task automatic test_saturation();
    doReset();
    issue(3'd1, 1'b1);
    src_addr = 6'o11;
    src_used = 2'b01;
    // 4368 periods of (accept + 15 stalls), then accept + 14 stalls = 65534.
    repeat (69903) @(posedge clk);
    @(negedge clk);
    #1;
    nChecks++;
    if (sCount !== 16'hFFFE) begin
      nErrors++;
      $display("FAIL sat_preload: got %0h expected fffe", sCount);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    nChecks++;
    if (sCount !== 16'hFFFF) begin
      nErrors++;
      $display("FAIL sat_hold: got %0h expected ffff", sCount);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    nChecks++;
    if (sCount !== 16'd0 || sFwdSel !== 10'd0 || sStall !== 1'b0 ||
        stall_count !== 16'd0 || fwd_sel !== 4'd0 || stall !== 1'b0) begin
      nErrors++;
      $display("FAIL sat_reset: count=%0h sel=%0h stall=%0b main=%0h/%0h/%0b expected all 0",
               sCount, sFwdSel, sStall, stall_count, fwd_sel, stall);
    end
  endtask

  initial begin
    pipe[1] = '0;
    pipe[2] = '0;
    mCount  = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_youngest_wins();
    test_load_use();
    test_freeze_flush();
    test_zero_unused();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
